// File: rtl/png_chunk_ctrl_pkg.sv
// Shared types and constants for the PNG chunk framer.
// Optional build macro: PNG_SIG_EN adds the two PNG signature states.
package png_chunk_ctrl_pkg;

    localparam int DATA_WD = 32;
    localparam int LEN_WD  = 32;
    localparam int CNT_WD  = LEN_WD - 2;

    localparam logic [DATA_WD-1:0] PNG_SIG0 = 32'h89504E47;
    localparam logic [DATA_WD-1:0] PNG_SIG1 = 32'h0D0A1A0A;

    localparam logic [DATA_WD-1:0] TYP_IHDR = 32'h49484452;
    localparam logic [DATA_WD-1:0] TYP_IDAT = 32'h49444154;
    localparam logic [DATA_WD-1:0] TYP_IEND = 32'h49454E44;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_TYPE = 3'd2,
        ST_DATA = 3'd3,
        ST_WCRC = 3'd4,
        ST_CRC  = 3'd5
`ifdef PNG_SIG_EN
        ,
        ST_SIG0 = 3'd6,
        ST_SIG1 = 3'd7
`endif
    } state_e;

endpackage

// File: rtl/png_chunk_ctrl_if.sv
// Payload, output-stream and crc32-engine signals of the chunk framer.
// master = framer side, slave = producer / writer / crc32 side.
interface png_chunk_ctrl_if;
    import png_chunk_ctrl_pkg::*;

    logic               pld_val_i;
    logic [DATA_WD-1:0] pld_dat_i;
    logic               pld_rdy_o;

    logic               out_val_o;
    logic [DATA_WD-1:0] out_dat_o;
    logic               out_rdy_i;

    logic               crc_start_o;
    logic               crc_val_o;
    logic [DATA_WD-1:0] crc_dat_o;
    logic               crc_lst_o;
    logic               crc_done_i;
    logic               crc_val_i;
    logic [DATA_WD-1:0] crc_dat_i;

    modport master (
        input  pld_val_i, pld_dat_i, out_rdy_i, crc_done_i, crc_val_i, crc_dat_i,
        output pld_rdy_o, out_val_o, out_dat_o, crc_start_o, crc_val_o, crc_dat_o, crc_lst_o
    );

    modport slave (
        output pld_val_i, pld_dat_i, out_rdy_i, crc_done_i, crc_val_i, crc_dat_i,
        input  pld_rdy_o, out_val_o, out_dat_o, crc_start_o, crc_val_o, crc_dat_o, crc_lst_o
    );

endinterface

// File: rtl/png_chunk_ctrl.sv
// PNG chunk framer: LENGTH, TYPE, payload, CRC words on a valid/ready stream,
// driving an external crc32 engine over TYPE+payload.
// Optional build macro: PNG_SIG_EN emits the PNG signature once after reset.
//
//  state | meaning
//  IDLE  | waiting for start_i
//  SIG0  | signature word 0 (PNG_SIG_EN only, first chunk after reset)
//  SIG1  | signature word 1 (PNG_SIG_EN only, first chunk after reset)
//  LEN   | length word, not hashed
//  TYPE  | type word, hashed
//  DATA  | payload pass-through, hashed
//  WCRC  | waiting for crc32 result
//  CRC   | CRC word
module png_chunk_ctrl
    import png_chunk_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [31:0]       typ_i,
    input  logic [LEN_WD-1:0] len_i,
    output logic              busy_o,
    output logic              err_o,
    output logic              done_o,
    png_chunk_ctrl_if.master  bus
);

    localparam logic [CNT_WD-1:0] CNT_ONE = CNT_WD'(1);

    state_e             state_q;
    logic [LEN_WD-1:0]  len_q;
    logic [31:0]        typ_q;
    logic [CNT_WD-1:0]  cnt_q;
    logic [31:0]        crc_q;
    logic               cap_q;
    logic               arm_q;
    logic               crc_start_q;
    logic               err_q;
    logic               done_q;
`ifdef PNG_SIG_EN
    logic               sig_pend_q;
`endif

    logic               out_val;
    logic [31:0]        out_dat;
    logic               pld_rdy;
    logic               crc_val;
    logic [31:0]        crc_dat;
    logic               crc_lst;
    logic               fire;
    logic               cap_now;
    logic               crc_ready;

    // Output word mux and crc32 feed, decoded from the current state.
    always_comb begin
        out_val = 1'b0;
        out_dat = '0;
        pld_rdy = 1'b0;
        crc_val = 1'b0;
        crc_dat = typ_q;
        crc_lst = 1'b0;
        case (state_q)
`ifdef PNG_SIG_EN
            ST_SIG0: begin
                out_val = 1'b1;
                out_dat = PNG_SIG0;
            end
            ST_SIG1: begin
                out_val = 1'b1;
                out_dat = PNG_SIG1;
            end
`endif
            ST_LEN: begin
                out_val = 1'b1;
                out_dat = len_q;
            end
            ST_TYPE: begin
                out_val = 1'b1;
                out_dat = typ_q;
                crc_val = bus.out_rdy_i;
                crc_lst = bus.out_rdy_i & (cnt_q == '0);
            end
            ST_DATA: begin
                out_val = bus.pld_val_i;
                out_dat = bus.pld_dat_i;
                pld_rdy = bus.out_rdy_i;
                crc_val = bus.pld_val_i & bus.out_rdy_i;
                crc_dat = bus.pld_dat_i;
                crc_lst = bus.pld_val_i & bus.out_rdy_i & (cnt_q == CNT_ONE);
            end
            ST_CRC: begin
                out_val = 1'b1;
                out_dat = crc_q;
            end
            default: ;
        endcase
    end

    assign fire      = out_val & bus.out_rdy_i;
    // A result may arrive in the same cycle the last word is hashed.
    assign cap_now   = bus.crc_val_i & (arm_q | crc_lst);
    assign crc_ready = cap_q | cap_now;

    assign bus.out_val_o   = out_val;
    assign bus.out_dat_o   = out_dat;
    assign bus.pld_rdy_o   = pld_rdy;
    assign bus.crc_val_o   = crc_val;
    assign bus.crc_dat_o   = crc_dat;
    assign bus.crc_lst_o   = crc_lst;
    assign bus.crc_start_o = crc_start_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign err_o           = err_q;
    assign done_o          = done_q;

    // Chunk sequencer with word counter, CRC capture and registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            typ_q       <= '0;
            cnt_q       <= '0;
            crc_q       <= '0;
            cap_q       <= 1'b0;
            arm_q       <= 1'b0;
            crc_start_q <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
`ifdef PNG_SIG_EN
            sig_pend_q  <= 1'b1;
`endif
        end else begin
            crc_start_q <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;

            if (cap_now) begin
                crc_q <= bus.crc_dat_i;
                cap_q <= 1'b1;
            end
            if (crc_lst) begin
                arm_q <= 1'b1;
            end else if (bus.crc_done_i) begin
                arm_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (len_i[1:0] != 2'b00) begin
                            err_q <= 1'b1;
                        end else begin
                            typ_q       <= typ_i;
                            len_q       <= len_i;
                            cnt_q       <= len_i[LEN_WD-1:2];
                            crc_start_q <= 1'b1;
                            cap_q       <= 1'b0;
                            arm_q       <= 1'b0;
`ifdef PNG_SIG_EN
                            state_q     <= sig_pend_q ? ST_SIG0 : ST_LEN;
`else
                            state_q     <= ST_LEN;
`endif
                        end
                    end
                end
`ifdef PNG_SIG_EN
                ST_SIG0: if (fire) state_q <= ST_SIG1;
                ST_SIG1: begin
                    if (fire) begin
                        sig_pend_q <= 1'b0;
                        state_q    <= ST_LEN;
                    end
                end
`endif
                ST_LEN: if (fire) state_q <= ST_TYPE;
                ST_TYPE: begin
                    if (fire) begin
                        if (cnt_q != '0) state_q <= ST_DATA;
                        else             state_q <= crc_ready ? ST_CRC : ST_WCRC;
                    end
                end
                ST_DATA: begin
                    if (fire) begin
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) state_q <= crc_ready ? ST_CRC : ST_WCRC;
                    end
                end
                ST_WCRC: if (crc_ready) state_q <= ST_CRC;
                ST_CRC: begin
                    if (fire) begin
                        done_q  <= 1'b1;
                        cap_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_png_chunk_ctrl.sv
// Scoreboard bench for png_chunk_ctrl with a behavioural crc32 engine.
module tb_png_chunk_ctrl;
    import png_chunk_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] typ = '0;
    logic [31:0] len = '0;
    logic        busy, err, done;

    logic        pld_val = 1'b0;
    logic [31:0] pld_dat = '0;
    logic        out_rdy = 1'b1;
    logic        eng_done, eng_val;
    logic [31:0] eng_dat;

    png_chunk_ctrl_if bus();

    assign bus.pld_val_i  = pld_val;
    assign bus.pld_dat_i  = pld_dat;
    assign bus.out_rdy_i  = out_rdy;
    assign bus.crc_done_i = eng_done;
    assign bus.crc_val_i  = eng_val;
    assign bus.crc_dat_i  = eng_dat;

    png_chunk_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .typ_i   (typ),
        .len_i   (len),
        .busy_o  (busy),
        .err_o   (err),
        .done_o  (done),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_errs = 0;
    int n_words = 0, n_crcval = 0, n_lst = 0, n_done = 0, n_errp = 0, n_cstart = 0;
    logic [31:0] lst_dat = '0;
    logic [31:0] sb[$];
    logic [31:0] pld_q[$];
    logic [31:0] cur_pl[$];
    int  rdy_mode = 0;
    bit  pld_en = 1'b1;
    bit  pld_take = 1'b0;
    bit  sig_pend = 1'b0;
    bit  hold_v = 1'b0;
    logic [31:0] hold_d = '0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [31:0] w);
        logic [31:0] r;
        r = c;
        for (int b = 3; b >= 0; b--) begin
            r = r ^ {24'h0, w[b*8 +: 8]};
            for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Behavioural crc32 engine: result three cycles after the last word.
    int          eng_lat;
    logic [31:0] eng_crc;
    always @(posedge clk) begin
        if (rst) begin
            eng_lat  <= 0;
            eng_done <= 1'b0;
            eng_val  <= 1'b0;
            eng_dat  <= '0;
            eng_crc  <= 32'hFFFFFFFF;
        end else begin
            eng_done <= 1'b0;
            eng_val  <= 1'b0;
            if (eng_lat > 0) eng_lat <= eng_lat - 1;
            if (eng_lat == 1) begin
                eng_val  <= 1'b1;
                eng_done <= 1'b1;
                eng_dat  <= ~eng_crc;
            end
            if (bus.crc_start_o) begin
                eng_crc <= 32'hFFFFFFFF;
            end else if (bus.crc_val_o) begin
                eng_crc <= crc_upd(eng_crc, bus.crc_dat_o);
                if (bus.crc_lst_o) eng_lat <= 3;
            end
        end
    end

    // Payload producer and downstream ready pattern.
    always @(posedge clk) begin
        #1;
        if (pld_take && pld_q.size() != 0) pld_q.delete(0);
        pld_val = pld_en && (pld_q.size() != 0);
        pld_dat = (pld_q.size() != 0) ? pld_q[0] : 32'h0;
        case (rdy_mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = ~out_rdy;
            default: out_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: scoreboard pop on every accepted word, event counters.
    always @(negedge clk) begin
        pld_take = pld_val && bus.pld_rdy_o;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && bus.out_val_o) chk_eq("stall_hold", bus.out_dat_o, hold_d);
            hold_v = bus.out_val_o && !bus.out_rdy_i;
            hold_d = bus.out_dat_o;
            if (bus.out_val_o && bus.out_rdy_i) begin
                n_words++;
                chk_eq("sb_empty_on_word", 32'(sb.size() == 0), 32'd0);
                if (sb.size() != 0) chk_eq("out_word", bus.out_dat_o, sb.pop_front());
            end
            if (bus.crc_val_o) begin
                n_crcval++;
                if (bus.crc_lst_o) begin
                    n_lst++;
                    lst_dat = bus.crc_dat_o;
                end
            end
            if (done) n_done++;
            if (err) n_errp++;
            if (bus.crc_start_o) n_cstart++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_sig();
        if (sig_pend) begin
            sb.push_back(PNG_SIG0);
            sb.push_back(PNG_SIG1);
            sig_pend = 1'b0;
        end
    endtask

    task automatic expect_chunk(input logic [31:0] t, input logic [31:0] l);
        logic [31:0] c;
        push_sig();
        c = crc_upd(32'hFFFFFFFF, t);
        sb.push_back(l);
        sb.push_back(t);
        foreach (cur_pl[i]) begin
            sb.push_back(cur_pl[i]);
            pld_q.push_back(cur_pl[i]);
            c = crc_upd(c, cur_pl[i]);
        end
        sb.push_back(~c);
    endtask

    task automatic pulse_start(input logic [31:0] t, input logic [31:0] l);
        start = 1'b1;
        typ   = t;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int k;
        d0 = n_done;
        k  = 0;
        while (n_done == d0 && k < budget) begin
            tick();
            k++;
        end
        chk_eq(tag, 32'(n_done != d0), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        sb.delete();
        pld_q.delete();
`ifdef PNG_SIG_EN
        sig_pend = 1'b1;
`else
        sig_pend = 1'b0;
`endif
        rst = 1'b0;
        tick();
    endtask

    int w0, c0, l0, d0, e0, s0;
    task automatic snap();
        w0 = n_words; c0 = n_crcval; l0 = n_lst; d0 = n_done; e0 = n_errp; s0 = n_cstart;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick(3);
        chk_eq("rst_busy", 32'(busy), 0);
        chk_eq("rst_out_val", 32'(bus.out_val_o), 0);
        chk_eq("rst_done_err", 32'({done, err}), 0);
        chk_eq("rst_crc_ctl", 32'({bus.crc_start_o, bus.crc_val_o, bus.crc_lst_o}), 0);
        chk_eq("rst_pld_rdy", 32'(bus.pld_rdy_o), 0);
        do_reset();

        // IEND, len 0, ready held high
        rdy_mode = 0;
        snap();
        push_sig();
        sb.push_back(32'h00000000);
        sb.push_back(TYP_IEND);
        sb.push_back(32'hAE426082);
        pulse_start(TYP_IEND, 0);
        chk_eq("iend_busy", 32'(busy), 1);
        wait_done("iend_done_seen", 200);
        tick(3);
        chk_eq("iend_sb_left", sb.size(), 0);
        chk_eq("iend_done_cnt", n_done - d0, 1);
        chk_eq("iend_crcval_cnt", n_crcval - c0, 1);
        chk_eq("iend_lst_cnt", n_lst - l0, 1);
        chk_eq("iend_lst_on_type", lst_dat, TYP_IEND);
        chk_eq("iend_crc_start", n_cstart - s0, 1);
        chk_eq("iend_busy_after", 32'(busy), 0);

        // IDAT, 8 bytes, ready toggling
        rdy_mode = 1;
        snap();
        cur_pl = '{32'h11223344, 32'h55667788};
        expect_chunk(TYP_IDAT, 8);
        pulse_start(TYP_IDAT, 8);
        wait_done("idat_done_seen", 300);
        tick(3);
        chk_eq("idat_sb_left", sb.size(), 0);
        chk_eq("idat_words", n_words - w0, 5);
        chk_eq("idat_crcval_cnt", n_crcval - c0, 3);
        chk_eq("idat_lst_word", lst_dat, 32'h55667788);
        chk_eq("idat_done_cnt", n_done - d0, 1);

        // misaligned length rejected
        rdy_mode = 0;
        snap();
        pulse_start(TYP_IDAT, 13);
        chk_eq("err_pulse_hi", 32'(err), 1);
        chk_eq("err_busy", 32'(busy), 0);
        tick();
        chk_eq("err_pulse_lo", 32'(err), 0);
        tick(10);
        chk_eq("err_pulse_cnt", n_errp - e0, 1);
        chk_eq("err_no_words", n_words - w0, 0);
        chk_eq("err_no_crc_start", n_cstart - s0, 0);

        // reset while stuck in DATA
        snap();
        pld_en = 1'b0;
        cur_pl = '{32'hDEADBEEF, 32'hCAFEF00D};
        expect_chunk(TYP_IDAT, 8);
        pulse_start(TYP_IDAT, 8);
        for (int k = 0; k < 40 && (n_words - w0) < 2; k++) tick();
        chk_eq("abort_words_before", n_words - w0, 2);
        tick(3);
        chk_eq("abort_in_data_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        chk_eq("abort_out_val", 32'(bus.out_val_o), 0);
        chk_eq("abort_busy", 32'(busy), 0);
        pld_en = 1'b1;
        do_reset();
        snap();
        cur_pl.delete();
        expect_chunk(TYP_IEND, 0);
        pulse_start(TYP_IEND, 0);
        wait_done("abort_iend_done", 200);
        tick(3);
        chk_eq("abort_iend_sb", sb.size(), 0);
        chk_eq("abort_no_stray_done", n_done - d0, 1);

        // start pulses while busy are ignored
        rdy_mode = 1;
        snap();
        cur_pl = '{32'hAABBCCDD};
        expect_chunk(TYP_IHDR, 4);
        pulse_start(TYP_IHDR, 4);
        tick();
        pulse_start(TYP_IEND, 0);
        pulse_start(TYP_IDAT, 13);
        wait_done("busy_done_seen", 300);
        tick(30);
        chk_eq("busy_sb_left", sb.size(), 0);
        chk_eq("busy_done_cnt", n_done - d0, 1);
        chk_eq("busy_no_err", n_errp - e0, 0);
        chk_eq("busy_crc_start", n_cstart - s0, 1);
        chk_eq("busy_crcval_cnt", n_crcval - c0, 2);
        chk_eq("busy_idle_after", 32'(busy), 0);

        // after reset: IHDR then IEND (signature only before the first)
        rdy_mode = 2;
        do_reset();
        snap();
        cur_pl = '{32'h00000010, 32'h00000020, 32'h08060000};
        expect_chunk(TYP_IHDR, 12);
        pulse_start(TYP_IHDR, 12);
        wait_done("sig_ihdr_done", 400);
        cur_pl.delete();
        expect_chunk(TYP_IEND, 0);
        pulse_start(TYP_IEND, 0);
        wait_done("sig_iend_done", 400);
        tick(3);
        chk_eq("sig_sb_left", sb.size(), 0);
        chk_eq("sig_done_cnt", n_done - d0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_errs);
        $finish;
    end

endmodule
